// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for one shared memory port, with
// per-transaction timeout abort and registered completion/err pulses.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_reqA,
  input  logic [31:0] i_addrA,
  input  logic [31:0] i_wdataA,
  input  logic        i_weA,
  input  logic        i_reqB,
  input  logic [31:0] i_addrB,
  input  logic [31:0] i_wdataB,
  input  logic        i_weB,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic        o_sel,
  output logic        o_doneA,
  output logic        o_doneB,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_lastB;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_sel;
  logic        r_doneA;
  logic        r_doneB;
  logic        r_err;
  logic [31:0] r_rdata;

  logic w_serving;
  logic w_finish;
  logic w_abort;
  logic w_grantA;
  logic w_grantB;

  // On a tie the requester that was not served last wins.
  assign w_grantA  = i_reqA & (~i_reqB | r_lastB);
  assign w_grantB  = i_reqB & (~i_reqA | ~r_lastB);
  assign w_serving = (r_state != IDLE);
  assign w_finish  = w_serving & i_mem_ready;
  assign w_abort   = w_serving & ~i_mem_ready & (r_cnt == LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantA)      w_next = SERVE_A;
        else if (w_grantB) w_next = SERVE_B;
      end
      SERVE_A, SERVE_B: begin
        if (w_finish || w_abort) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lastB <= 1'b1;
      r_cnt   <= 8'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_sel   <= 1'b0;
      r_doneA <= 1'b0;
      r_doneB <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_doneA <= w_finish & (r_state == SERVE_A);
      r_doneB <= w_finish & (r_state == SERVE_B);
      r_err   <= w_abort;
      if (r_state == IDLE) begin
        r_cnt <= 8'd0;
        if (w_grantA) begin
          r_addr  <= i_addrA;
          r_wdata <= i_wdataA;
          r_we    <= i_weA;
          r_sel   <= 1'b0;
        end else if (w_grantB) begin
          r_addr  <= i_addrB;
          r_wdata <= i_wdataB;
          r_we    <= i_weB;
          r_sel   <= 1'b1;
        end
      end else begin
        if (!i_mem_ready) r_cnt <= r_cnt + 8'd1;
        if (w_finish || w_abort) r_lastB <= (r_state == SERVE_B);
        if (w_finish && !r_we) r_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_valid = w_serving;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_we    = r_we;
  assign o_sel       = r_sel;
  assign o_doneA     = r_doneA;
  assign o_doneB     = r_doneB;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqA = 1'b0, weA = 1'b0, reqB = 1'b0, weB = 1'b0;
  logic [31:0] addrA = '0, wdataA = '0, addrB = '0, wdataB = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid, mem_we, sel, doneA, doneB, err;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_reqA(reqA), .i_addrA(addrA), .i_wdataA(wdataA), .i_weA(weA),
    .i_reqB(reqB), .i_addrB(addrB), .i_wdataB(wdataB), .i_weB(weB),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .o_sel(sel), .o_doneA(doneA), .o_doneB(doneB),
    .o_rdata(rdata), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_valid"}, {31'd0, mem_valid}, 32'd0);
    check({tag, "_doneA"}, {31'd0, doneA}, 32'd0);
    check({tag, "_doneB"}, {31'd0, doneB}, 32'd0);
    check({tag, "_err"},   {31'd0, err},   32'd0);
  endtask

  initial begin
    // Reset state
    #3;
    checkIdle("rst");
    check("rst_sel",   {31'd0, sel}, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_we",    {31'd0, mem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    tick();
    rst_n = 1'b1;

    // Single read from A; request dropped mid-transaction
    reqA = 1'b1; addrA = 32'h0000_0040;
    tick();
    check("rdA_valid", {31'd0, mem_valid}, 32'd1);
    check("rdA_sel",   {31'd0, sel}, 32'd0);
    check("rdA_addr",  mem_addr, 32'h0000_0040);
    check("rdA_we",    {31'd0, mem_we}, 32'd0);
    reqA = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("rdA_done",  {31'd0, doneA}, 32'd1);
    check("rdA_valid0", {31'd0, mem_valid}, 32'd0);
    check("rdA_rdata", rdata, 32'hDEAD_BEEF);
    mem_ready = 1'b0;
    tick();
    check("rdA_pulse", {31'd0, doneA}, 32'd0);

    // Write from B; inputs changed during SERVE must be ignored
    reqB = 1'b1; weB = 1'b1; addrB = 32'h0000_1000; wdataB = 32'h1234_5678;
    tick();
    reqB = 1'b0; addrB = 32'h0000_2222; wdataB = 32'h0; weB = 1'b0;
    tick();
    check("wrB_valid", {31'd0, mem_valid}, 32'd1);
    check("wrB_we",    {31'd0, mem_we}, 32'd1);
    check("wrB_addr",  mem_addr, 32'h0000_1000);
    check("wrB_wdata", mem_wdata, 32'h1234_5678);
    check("wrB_sel",   {31'd0, sel}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    check("wrB_done",  {31'd0, doneB}, 32'd1);
    check("wrB_doneA", {31'd0, doneA}, 32'd0);
    check("wrB_rdata", rdata, 32'hDEAD_BEEF);
    tick();
    checkIdle("rdyIdle");
    check("selHold", {31'd0, sel}, 32'd1);
    mem_ready = 1'b0;

    // Contention from reset: grants alternate A,B,A,B
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    reqA = 1'b1; reqB = 1'b1; weA = 1'b0; weB = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1111_0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        check("rr_valid", {31'd0, mem_valid}, 32'd1);
        check("rr_sel",   {31'd0, sel}, 32'((i / 2) % 2));
      end else begin
        check("rr_valid0", {31'd0, mem_valid}, 32'd0);
        check("rr_doneA",  {31'd0, doneA}, 32'((i / 2) % 2 == 0));
        check("rr_doneB",  {31'd0, doneB}, 32'((i / 2) % 2 == 1));
      end
    end
    reqA = 1'b0; reqB = 1'b0; mem_ready = 1'b0;
    tick();

    // Timeout abort after 4 SERVE cycles
    reqA = 1'b1; mem_rdata = 32'h9999_9999;
    tick();
    reqA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_valid", {31'd0, mem_valid}, 32'd1);
      check("to_err0",  {31'd0, err}, 32'd0);
    end
    tick();
    check("to_err",   {31'd0, err}, 32'd1);
    check("to_doneA", {31'd0, doneA}, 32'd0);
    check("to_valid0", {31'd0, mem_valid}, 32'd0);
    check("to_rdata", rdata, 32'h1111_0000);
    tick();
    check("to_errPulse", {31'd0, err}, 32'd0);

    // Ready on the 4th SERVE cycle wins over timeout
    reqA = 1'b1;
    tick();
    reqA = 1'b0;
    tick();
    tick();
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    check("late_done",  {31'd0, doneA}, 32'd1);
    check("late_err",   {31'd0, err}, 32'd0);
    check("late_rdata", rdata, 32'h4444_4444);
    mem_ready = 1'b0;
    tick();

    // Reset mid-access in SERVE_B
    reqB = 1'b1;
    tick();
    reqB = 1'b0;
    check("mid_valid", {31'd0, mem_valid}, 32'd1);
    check("mid_sel",   {31'd0, sel}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid0", {31'd0, mem_valid}, 32'd0);
    check("mid_sel0",   {31'd0, sel}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    checkIdle("midAfter");
    mem_ready = 1'b0;
    reqA = 1'b1; reqB = 1'b1;
    tick();
    check("mid_tieValid", {31'd0, mem_valid}, 32'd1);
    check("mid_tieSel",   {31'd0, sel}, 32'd0);
    reqA = 1'b0; reqB = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles SERVE state waits for mem_ready before abort (legal range 1..255).
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clk.
REQ-004 reqA  input  1  requester A (instruction fetch) transaction request.
REQ-005 addrA, wdataA  input  32 each  requester A address / write data.
REQ-006 weA  input  1  requester A write enable (1=write, 0=read).
REQ-007 reqB, addrB, wdataB, weB  input  1/32/32/1  requester B (data access), same meaning as A.
REQ-008 mem_ready  input  1  shared port completes current access this cycle.
REQ-009 mem_rdata  input  32  shared port read data, valid when mem_ready=1.
REQ-010 mem_valid  output  1  shared port access in progress.
REQ-011 mem_addr, mem_wdata  output  32 each  registered address/write data of granted requester.
REQ-012 mem_we  output  1  registered write enable of granted requester.
REQ-013 sel  output  1  owner select: 0=A, 1=B (drives shared 2:1 word muxes).
REQ-014 doneA, doneB  output  1 each  one-cycle completion pulse to requester.
REQ-015 rdata  output  32  registered read data of last completed access.
REQ-016 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-017 FSM states SHALL be IDLE, SERVE_A, SERVE_B; no other reachable states.
REQ-018 IDLE: reqA=1,reqB=0 -> SERVE_A; reqB=1,reqA=0 -> SERVE_B; both -> requester not served last (round-robin); neither -> stay IDLE.
REQ-019 On leaving IDLE, SHALL register granted requester's addr/wdata/we into mem_addr/mem_wdata/mem_we and set sel; these hold constant until return to IDLE.
REQ-020 mem_valid SHALL equal 1 exactly while in SERVE_A or SERVE_B.
REQ-021 In SERVE_x with mem_ready=1: rdata<=mem_rdata (reads only; writes leave rdata unchanged), doneX pulses next cycle, last-served<=x, state->IDLE.
REQ-022 Latency: request accepted at edge N, mem_ready=1 in cycle N+1 -> doneX high in cycle N+2; next grant earliest at edge N+2.
REQ-023 Wait counter (8 bits) SHALL clear on entry to SERVE_x and increment each SERVE cycle with mem_ready=0.
REQ-024 Counter reaching TIMEOUT with mem_ready=0: state->IDLE, err pulses one cycle, no doneX, rdata unchanged, last-served<=x.
REQ-025 mem_ready=1 on the same cycle count reaches TIMEOUT SHALL complete normally (ready wins, no err).
REQ-026 Requests dropped or changed during SERVE SHALL be ignored; transaction completes with registered values.
REQ-027 mem_ready while IDLE SHALL be ignored.
REQ-028 sel SHALL hold its last value in IDLE.
REQ-029 doneA, doneB, err SHALL be mutually exclusive and never high two consecutive cycles for the same transaction.

Reset
REQ-030 Reset=0 SHALL immediately force IDLE, mem_valid=0, mem_addr=mem_wdata=0, mem_we=0, sel=0, doneA=doneB=err=0, rdata=0, counter=0, last-served=B (A wins first tie).
REQ-031 Reset asserted during SERVE SHALL abort the access with no done/err pulse; first edge after release samples requests normally.

Verification
REQ-032 Single read: reqA=1, addrA=0x00000040; mem_ready=1 next cycle with mem_rdata=0xDEADBEEF -> mem_valid one cycle, sel=0, doneA one cycle later, rdata=0xDEADBEEF.
REQ-033 Contention: reqA=reqB=1 held, mem_ready tied 1 -> grants alternate A,B,A,B from reset; sel 0,1,0,1; doneA/doneB alternate every 2 cycles.
REQ-034 Write: reqB=1, weB=1, addrB=0x1000, wdataB=0x12345678 -> mem_we=1, mem_addr=0x1000, mem_wdata=0x12345678, sel=1 while mem_valid; rdata unchanged after doneB.
REQ-035 Timeout: TIMEOUT=4, reqA=1, mem_ready held 0 -> err pulses after 4 SERVE cycles, no doneA, state IDLE; mem_ready=1 on 4th cycle instead -> doneA, no err.
REQ-036 Reset mid-access: in SERVE_B, Reset=0 between edges -> mem_valid and sel drop to 0 immediately; after release no doneB; next tie grants A.
